dataflow_gates: RTL and testbench

- Registered two-input logic-gate bank. Computes AND, OR, NAND, NOR, XOR and XNOR of operands a and b, and NOT of a, bitwise over WIDTH bits.
- Captures results on a valid strobe and presents them with one-cycle latency.
- Used as a leaf primitive and as a bring-up/self-check block for basic logic.

---
 rtl/dataflow_gates_pkg.sv | 18 +
 rtl/gate_bank_comb.sv | 27 ++
 rtl/dataflow_gates.sv | 76 +++++++
 tb/tb_dataflow_gates.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_gates_pkg.sv
// Shared definitions for the registered logic-gate bank.
package dataflow_gates_pkg;

    // Default operand/result width when the parent does not override it.
    localparam int DEFAULT_WIDTH = 1;

    // Result-select encoding, reserved for a future muxed single-output view.
    typedef enum logic [2:0] {
        SEL_AND  = 3'd0,
        SEL_OR   = 3'd1,
        SEL_NAND = 3'd2,
        SEL_NOR  = 3'd3,
        SEL_XOR  = 3'd4,
        SEL_XNOR = 3'd5,
        SEL_NOT  = 3'd6
    } gate_sel_e;

endpackage

// File: rtl/gate_bank_comb.sv
// Purely combinational gate bank: maps operands a/b to the seven bitwise results.
module gate_bank_comb
    import dataflow_gates_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_and,
    output logic [WIDTH-1:0] res_or,
    output logic [WIDTH-1:0] res_nand,
    output logic [WIDTH-1:0] res_nor,
    output logic [WIDTH-1:0] res_xor,
    output logic [WIDTH-1:0] res_xnor,
    output logic [WIDTH-1:0] res_not
);

    // Every result is strictly per-bit; no bit ever looks at a neighbour.
    assign res_and  = a & b;
    assign res_or   = a | b;
    assign res_nand = ~(a & b);
    assign res_nor  = ~(a | b);
    assign res_xor  = a ^ b;
    assign res_xnor = ~(a ^ b);
    assign res_not  = ~a;

endmodule

// File: rtl/dataflow_gates.sv
// Registered two-input gate bank: captures all gate results on in_valid,
// presents them one cycle later with out_valid.
module dataflow_gates
    import dataflow_gates_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out_and,
    output logic [WIDTH-1:0] out_or,
    output logic [WIDTH-1:0] out_nand,
    output logic [WIDTH-1:0] out_nor,
    output logic [WIDTH-1:0] out_xor,
    output logic [WIDTH-1:0] out_xnor,
    output logic [WIDTH-1:0] out_not,
    output logic             out_valid
);

    logic [WIDTH-1:0] res_and;
    logic [WIDTH-1:0] res_or;
    logic [WIDTH-1:0] res_nand;
    logic [WIDTH-1:0] res_nor;
    logic [WIDTH-1:0] res_xor;
    logic [WIDTH-1:0] res_xnor;
    logic [WIDTH-1:0] res_not;

    gate_bank_comb #(
        .WIDTH(WIDTH)
    ) u_bank (
        .a       (a),
        .b       (b),
        .res_and (res_and),
        .res_or  (res_or),
        .res_nand(res_nand),
        .res_nor (res_nor),
        .res_xor (res_xor),
        .res_xnor(res_xnor),
        .res_not (res_not)
    );

    // out_valid is simply in_valid delayed by one clock; reset clears it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Result registers load on in_valid and hold otherwise; reset value is all-zeros
    // for every output, including the inverting gates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_and  <= '0;
            out_or   <= '0;
            out_nand <= '0;
            out_nor  <= '0;
            out_xor  <= '0;
            out_xnor <= '0;
            out_not  <= '0;
        end else if (in_valid) begin
            out_and  <= res_and;
            out_or   <= res_or;
            out_nand <= res_nand;
            out_nor  <= res_nor;
            out_xor  <= res_xor;
            out_xnor <= res_xnor;
            out_not  <= res_not;
        end
    end

endmodule

// File: tb/tb_dataflow_gates.sv
// Self-checking bench for dataflow_gates: truth-table model plus directed vectors.
module tb_dataflow_gates;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out_and;
    logic [W-1:0] out_or;
    logic [W-1:0] out_nand;
    logic [W-1:0] out_nor;
    logic [W-1:0] out_xor;
    logic [W-1:0] out_xnor;
    logic [W-1:0] out_not;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: per-gate truth tables indexed by {a[i], b[i]}.
    // Order: and, or, nand, nor, xor, xnor, not.
    logic [3:0]   tt [7];
    logic [W-1:0] m_res [7];
    logic         m_valid;

    dataflow_gates #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_and  (out_and),
        .out_or   (out_or),
        .out_nand (out_nand),
        .out_nor  (out_nor),
        .out_xor  (out_xor),
        .out_xnor (out_xnor),
        .out_not  (out_not),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Look up gate g for operands x/y one bit at a time through its truth table.
    function automatic logic [W-1:0] model_gate(input int g, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [3:0]   t;
        t = tt[g];
        for (int i = 0; i < W; i++) begin
            r[i] = t[{x[i], y[i]}];
        end
        return r;
    endfunction

    // Model state: async clear, capture on in_valid, valid follows in_valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            for (int g = 0; g < 7; g++) m_res[g] <= '0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                for (int g = 0; g < 7; g++) m_res[g] <= model_gate(g, a, b);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        checkOutput("and",   out_and,  m_res[0]);
        checkOutput("or",    out_or,   m_res[1]);
        checkOutput("nand",  out_nand, m_res[2]);
        checkOutput("nor",   out_nor,  m_res[3]);
        checkOutput("xor",   out_xor,  m_res[4]);
        checkOutput("xnor",  out_xnor, m_res[5]);
        checkOutput("not",   out_not,  m_res[6]);
        checkOutput("valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, m_valid});
        if (out_valid) begin
            checkOutput("nand_ident", out_nand, ~out_and);
            checkOutput("nor_ident",  out_nor,  ~out_or);
            checkOutput("xnor_ident", out_xnor, ~out_xor);
        end
    end

    // Drive a new input set a little after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk);
        #2;
        in_valid = v;
        a        = x;
        b        = y;
    endtask

    // Check DUT and model against hand-computed literals.
    task automatic checkLiterals(input string tag, input logic [W-1:0] e_and,
                                 input logic [W-1:0] e_or, input logic [W-1:0] e_nand,
                                 input logic [W-1:0] e_nor, input logic [W-1:0] e_xor,
                                 input logic [W-1:0] e_xnor, input logic [W-1:0] e_not,
                                 input logic e_valid);
        checkOutput({tag, "_and"},   out_and,  e_and);
        checkOutput({tag, "_or"},    out_or,   e_or);
        checkOutput({tag, "_nand"},  out_nand, e_nand);
        checkOutput({tag, "_nor"},   out_nor,  e_nor);
        checkOutput({tag, "_xor"},   out_xor,  e_xor);
        checkOutput({tag, "_xnor"},  out_xnor, e_xnor);
        checkOutput({tag, "_not"},   out_not,  e_not);
        checkOutput({tag, "_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, e_valid});
        checkOutput({tag, "_model_and"},  m_res[0], e_and);
        checkOutput({tag, "_model_nand"}, m_res[2], e_nand);
        checkOutput({tag, "_model_xor"},  m_res[4], e_xor);
        checkOutput({tag, "_model_not"},  m_res[6], e_not);
    endtask

    // Capture one vector then check literals on the following cycle.
    task automatic captureAndCheck(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] e_and, input logic [W-1:0] e_or,
                                   input logic [W-1:0] e_nand, input logic [W-1:0] e_nor,
                                   input logic [W-1:0] e_xor, input logic [W-1:0] e_xnor,
                                   input logic [W-1:0] e_not);
        applyStimulus(1'b1, x, y);
        @(posedge clk);
        #3;
        checkLiterals(tag, e_and, e_or, e_nand, e_nor, e_xor, e_xnor, e_not, 1'b1);
    endtask

    // Main directed sequence.
    initial begin
        tt[0] = 4'b1000;
        tt[1] = 4'b1110;
        tt[2] = 4'b0111;
        tt[3] = 4'b0001;
        tt[4] = 4'b0110;
        tt[5] = 4'b1001;
        tt[6] = 4'b0011;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'b1010;
        b        = 4'b0101;
        #3;
        checkLiterals("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Truth-table rows, each replicated across all bits.
        captureAndCheck("tt00", 4'b0000, 4'b0000,
                        4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111);
        captureAndCheck("tt01", 4'b0000, 4'b1111,
                        4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
        captureAndCheck("tt10", 4'b1111, 4'b0000,
                        4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        captureAndCheck("tt11", 4'b1111, 4'b1111,
                        4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000);

        // Hold: capture (1,0), then drop in_valid and change operands.
        captureAndCheck("cap10", 4'b1111, 4'b0000,
                        4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 4'b1111);
        @(posedge clk);
        #3;
        checkLiterals("hold", 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0);

        // All four truth-table rows at once across the bits.
        captureAndCheck("w4", 4'b1100, 4'b1010,
                        4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011);

        // Back-to-back random captures, then reset pulsed between edges.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, W'($urandom), W'($urandom));
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkLiterals("midrst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 4'b0110;
        b        = 4'b0011;
        @(posedge clk);
        #3;
        checkLiterals("postrst", 4'b0010, 4'b0111, 4'b1101, 4'b1000, 4'b0101, 4'b1010, 4'b1001, 1'b1);

        // Random regression against the model.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end
        applyStimulus(1'b0, 4'h0, 4'h0);
        @(posedge clk);
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
